inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch stage that sits directly upstream of the IF_ID pipeline register. It owns the program counter and issues one instruction-memory request at a time over a req/ack handshake. It redirects on branches, discarding any stale in-flight fetch, and presents `if_pc`/`if_inst`/`if_valid` to IF_ID, holding them under `stall` through a one-entry skid buffer.

## Interface
- `RESET_PC`, default 32'h00000000: address of the first fetch after reset.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: from pipeline control; output slot is consumed at a posedge only when `if_valid && !stall`.
- `branch_flag` in 1: redirect request, sampled at posedge.
- `branch_target` in 32: redirect address; bits [1:0] ignored (treated as 0).
- `mem_req` out 1: instruction-memory request.
- `mem_addr` out 32: request address; stable while `mem_req` is high.
- `mem_ack` in 1: read data valid this cycle; may assert in the same cycle as `mem_req`.
- `mem_rdata` in 32: instruction word, sampled when `mem_ack` is high.
- `if_pc` out 32: address of the presented instruction.
- `if_inst` out 32: presented instruction word.
- `if_valid` out 1: output slot holds a valid instruction.

## Operation
- Registers:
  - `pc`: next address to request.
  - `req_addr`: drives `mem_addr`.
  - `state`: one of IDLE, REQ, DROP.
  - Output slot: `if_pc`, `if_inst`, `if_valid`.
  - Skid entry: `skid_pc`, `skid_inst`, `skid_valid`.
- `mem_req = (state==REQ || state==DROP)`, decoded from `state` only.
- Issue action means `req_addr <= pc` and `pc <= pc + 4`. Arithmetic is mod 2^32, so 32'hFFFFFFFC wraps to 0.
- Priority at each posedge with `rst=0`: branch, then ack handling, then consumption.
- Branch (`branch_flag=1`):
  - Set `if_valid <= 0` and `skid_valid <= 0`; the ack handler and consumer do not act this edge.
  - If in REQ or DROP and `mem_ack=0`: `pc <= target`, go to DROP; `req_addr` stays unchanged.
  - Otherwise (IDLE, or ack this cycle): `req_addr <= target`, `pc <= target + 4`, go to REQ. Ack data this cycle is discarded.
- REQ with `mem_ack=1`:
  - If `skid_valid=0` and (`if_valid=0` or `stall=0`): the word goes to the output slot (`if_pc <= req_addr`, `if_inst <= mem_rdata`, `if_valid <= 1`).
  - Otherwise the word goes to the skid entry.
  - Next state: IDLE if the skid will be full after this edge; otherwise stay in REQ and perform the issue action.
- DROP with `mem_ack=1`: discard the data, perform the issue action (`pc` already holds the target), go to REQ.
- REQ or DROP with `mem_ack=0`: hold all fetch state.
- IDLE: go to REQ and perform the issue action at the first edge where the skid is empty after that edge.
- Consumption (`if_valid && !stall`):
  - If `skid_valid`: move the skid entry into the output slot and clear `skid_valid`.
  - Else, if no word is written to the slot this edge: `if_valid <= 0`.
- Ordering is strictly program order. The skid fills only while the slot is full and stalled. No request is issued while the skid is full.

## Timing
- Reset (any edge with `rst=1`):
  - `state <= IDLE`, `pc <= RESET_PC`, `req_addr <= RESET_PC`.
  - `if_pc`, `if_inst`, `skid_pc`, `skid_inst` reset to 0; `if_valid` and `skid_valid` reset to 0.
  - Therefore `mem_req=0` and `mem_addr=RESET_PC`.
- Reset mid-request: the outstanding request is abandoned and a late `mem_ack` is ignored (state is IDLE).
- First `mem_req` is high in the second cycle after `rst` falls (IDLE→REQ at the first edge).
- Latency: a word acked in cycle N is on `if_*` in cycle N+1.
- Zero-wait memory (ack same cycle as req) gives 1 instruction/cycle sustained.
- Stall with zero-wait memory:
  - One extra word is accepted into the skid, then `mem_req` drops.
  - After `stall` falls, `mem_req` reasserts one cycle later.
- Branch then redirect: the first target-path word appears 2 cycles after the branch edge with zero-wait memory. Wrong-path words never reach `if_valid=1`.
- A branch and `mem_ack` on the same edge: the ack data is dropped and the target is requested next cycle.

## Test plan
- **Reset and stream:** `RESET_PC=0x100`, `mem_ack` tied to `mem_req`, `rdata=addr^0xA5A5A5A5` → `if_pc` = 0x100, 0x104, 0x108 on consecutive cycles starting 2 cycles after reset release; `if_inst` matches.
- **Stall/skid:** stream, then `stall=1` for 4 cycles → slot holds X; exactly one further word enters the skid; `mem_req=0` for the remaining stalled cycles. On release, X, X+4, X+8 appear with no loss or duplication.
- **Branch while waiting:** memory acks 3 cycles late; branch to 0x2000 one cycle after a req to 0x40 → state DROP with `mem_addr` held at 0x40. The 0x40 data is discarded; the next request is to 0x2000; first valid `if_pc` = 0x2000.
- **Branch with simultaneous ack:** `branch_flag` and `mem_ack` on the same edge, target 0x300 → `if_valid=0` next cycle, then `if_pc=0x300`.
- **Wrap and alignment:** branch to 0xFFFFFFFF → requests are 0xFFFFFFFC then 0x00000000.
- **Reset mid-operation:** `rst` pulsed while stalled with the skid full → all outputs return to their reset values; the fetch restarts at `RESET_PC`; stale ack data is never presented.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, issues one req/ack memory fetch at a time,
// and presents program-ordered instructions to IF_ID through a one-entry skid buffer.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] req_addr;
    logic [31:0] skid_pc;
    logic [31:0] skid_inst;
    logic        skid_valid;

    logic [31:0] target;
    logic        ack_take;
    logic        slot_free;
    logic        to_slot;
    logic        to_skid;
    logic        consume;
    logic        skid_full_next;
    logic        issue;
    logic        redirect_req;
    logic        redirect_pc;

    assign mem_req  = (state == REQ) || (state == DROP);
    assign mem_addr = req_addr;

    always_comb begin
        target         = {branch_target[31:2], 2'b00};
        ack_take       = (state == REQ) && mem_ack && !branch_flag;
        slot_free      = !skid_valid && (!if_valid || !stall);
        to_slot        = ack_take && slot_free;
        to_skid        = ack_take && !slot_free;
        consume        = if_valid && !stall && !branch_flag;
        skid_full_next = !branch_flag && (to_skid || (skid_valid && !consume));

        state_next   = state;
        issue        = 1'b0;
        redirect_req = 1'b0;
        redirect_pc  = 1'b0;

        // A redirect with a fetch still outstanding must wait out that fetch in DROP.
        if (branch_flag) begin
            if ((state != IDLE) && !mem_ack) begin
                state_next  = DROP;
                redirect_pc = 1'b1;
            end else begin
                state_next   = REQ;
                redirect_req = 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (!skid_full_next) begin
                        state_next = REQ;
                        issue      = 1'b1;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        if (skid_full_next) begin
                            state_next = IDLE;
                        end else begin
                            issue = 1'b1;
                        end
                    end
                end
                DROP: begin
                    if (mem_ack) begin
                        state_next = REQ;
                        issue      = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            if_pc      <= '0;
            if_inst    <= '0;
            if_valid   <= 1'b0;
            skid_pc    <= '0;
            skid_inst  <= '0;
            skid_valid <= 1'b0;
        end else begin
            if (redirect_req) begin
                req_addr <= target;
                pc       <= target + 32'd4;
            end else if (redirect_pc) begin
                pc <= target;
            end else if (issue) begin
                req_addr <= pc;
                pc       <= pc + 32'd4;
            end

            if (branch_flag) begin
                if_valid   <= 1'b0;
                skid_valid <= 1'b0;
            end else begin
                if (to_slot) begin
                    if_pc    <= req_addr;
                    if_inst  <= mem_rdata;
                    if_valid <= 1'b1;
                end else if (consume) begin
                    if (skid_valid) begin
                        if_pc   <= skid_pc;
                        if_inst <= skid_inst;
                    end else begin
                        if_valid <= 1'b0;
                    end
                end

                if (to_skid) begin
                    skid_pc    <= req_addr;
                    skid_inst  <= mem_rdata;
                    skid_valid <= 1'b1;
                end else if (consume && skid_valid) begin
                    skid_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus randomized stall/branch/ack traffic
// checked against a program-order stream model and an address-hold rule.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;

    localparam logic [31:0] RPC = 32'h00000100;

    inst_fetch #(.RESET_PC(RPC)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_flag  (branch_flag),
        .branch_target(branch_target),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_valid     (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned consumed = 0;
    int          mode     = 0;   // 0: ack tied to req, 1: random ack, 2: fixed latency
    int          lat      = 0;
    int          wait_cnt = 0;
    bit          stray    = 1'b0;
    logic [31:0] exp_pc;
    logic        prev_req  = 1'b0;
    logic        prev_ack  = 1'b0;
    logic        prev_rst  = 1'b1;
    logic [31:0] prev_addr = '0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hA5A5A5A5;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive memory for the current cycle, update the stream model, then advance one clock.
    task automatic tick();
        if (stray) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hDEADBEEF;
        end else begin
            case (mode)
                0:       mem_ack = mem_req;
                1:       mem_ack = mem_req && ($urandom_range(0, 2) != 0);
                default: mem_ack = mem_req && (wait_cnt >= lat);
            endcase
            mem_rdata = mem_ack ? word_at(mem_addr) : $urandom;
        end
        wait_cnt = (mem_req && !mem_ack) ? wait_cnt + 1 : 0;

        if (prev_req && !prev_ack && !prev_rst && mem_req)
            check("addr_hold", mem_addr, prev_addr);
        prev_req  = mem_req;
        prev_ack  = mem_ack;
        prev_rst  = rst;
        prev_addr = mem_addr;

        if (rst) begin
            exp_pc = RPC;
        end else if (branch_flag) begin
            exp_pc = {branch_target[31:2], 2'b00};
        end else if (if_valid && !stall) begin
            check("stream_pc", if_pc, exp_pc);
            check("stream_inst", if_inst, word_at(exp_pc));
            exp_pc = exp_pc + 32'd4;
            consumed++;
        end

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_branch(input logic [31:0] t);
        branch_flag   = 1'b1;
        branch_target = t;
        tick();
        branch_flag = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        stall         = 1'b0;
        branch_flag   = 1'b0;
        branch_target = '0;
        mem_ack       = 1'b0;
        mem_rdata     = '0;
        exp_pc        = RPC;
        @(negedge clk);
        tick();
        tick();

        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, RPC);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_inst", if_inst, 32'd0);

        // Reset and zero-wait stream
        rst = 1'b0;
        tick();
        check("first_req", {31'd0, mem_req}, 32'd1);
        check("first_addr", mem_addr, RPC);
        check("first_valid", {31'd0, if_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stream_valid", {31'd0, if_valid}, 32'd1);
            check("stream_if_pc", if_pc, RPC + 32'(4 * i));
            check("stream_if_inst", if_inst, word_at(RPC + 32'(4 * i)));
        end

        // Stall with skid: slot holds 0x108, one more word accepted, requests stop
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_hold_pc", if_pc, 32'h108);
            check("stall_valid", {31'd0, if_valid}, 32'd1);
            check("stall_no_req", {31'd0, mem_req}, 32'd0);
        end
        stall = 1'b0;
        tick();
        check("release_req", {31'd0, mem_req}, 32'd1);
        check("release_pc0", if_pc, 32'h10C);
        tick();
        check("release_pc1", if_pc, 32'h110);
        tick();
        check("release_pc2", if_pc, 32'h114);

        // Branch with simultaneous ack
        do_branch(32'h300);
        check("bra_ack_valid", {31'd0, if_valid}, 32'd0);
        check("bra_ack_addr", mem_addr, 32'h300);
        tick();
        check("bra_ack_first_valid", {31'd0, if_valid}, 32'd1);
        check("bra_ack_first_pc", if_pc, 32'h300);

        // Wrap and alignment
        do_branch(32'hFFFFFFFF);
        check("wrap_addr0", mem_addr, 32'hFFFFFFFC);
        tick();
        check("wrap_addr1", mem_addr, 32'h00000000);
        check("wrap_pc0", if_pc, 32'hFFFFFFFC);
        tick();
        check("wrap_pc1", if_pc, 32'h00000000);

        // Branch while waiting on a slow memory
        mode = 2;
        lat  = 3;
        rst  = 1'b1;
        tick();
        rst = 1'b0;
        do_branch(32'h40);
        check("slow_req_addr", mem_addr, 32'h40);
        do_branch(32'h2000);
        check("drop_req", {31'd0, mem_req}, 32'd1);
        check("drop_addr", mem_addr, 32'h40);
        check("drop_valid", {31'd0, if_valid}, 32'd0);
        for (int i = 0; i < 10 && mem_addr == 32'h40; i++) begin
            tick();
            check("drop_no_valid", {31'd0, if_valid}, 32'd0);
        end
        check("drop_next_addr", mem_addr, 32'h2000);
        for (int i = 0; i < 10 && !if_valid; i++) tick();
        check("drop_first_valid", {31'd0, if_valid}, 32'd1);
        check("drop_first_pc", if_pc, 32'h2000);
        check("drop_first_inst", if_inst, word_at(32'h2000));

        // Reset while stalled with the skid full; stale ack during/after reset
        mode = 0;
        for (int i = 0; i < 3; i++) tick();
        stall = 1'b1;
        tick();
        tick();
        rst   = 1'b1;
        stray = 1'b1;
        tick();
        check("midrst_valid", {31'd0, if_valid}, 32'd0);
        check("midrst_pc", if_pc, 32'd0);
        check("midrst_inst", if_inst, 32'd0);
        check("midrst_req", {31'd0, mem_req}, 32'd0);
        check("midrst_addr", mem_addr, RPC);
        rst   = 1'b0;
        stall = 1'b0;
        tick();
        check("stale_ack_valid", {31'd0, if_valid}, 32'd0);
        check("restart_addr", mem_addr, RPC);
        stray = 1'b0;
        tick();
        check("restart_pc0", if_pc, RPC);
        check("restart_inst0", if_inst, word_at(RPC));
        tick();
        check("restart_pc1", if_pc, RPC + 32'd4);

        // Randomized traffic against the stream model
        mode     = 1;
        consumed = 0;
        for (int i = 0; i < 600; i++) begin
            stall         = ($urandom_range(0, 9) < 3);
            branch_flag   = ($urandom_range(0, 19) == 0);
            branch_target = $urandom;
            tick();
        end
        stall       = 1'b0;
        branch_flag = 1'b0;
        mode        = 0;
        for (int i = 0; i < 5; i++) tick();
        check("progress", {31'd0, consumed > 50}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
